mcu_cmd_link: RTL

- Parametrised successor of the front-panel MCU serial command link: a 3-wire open-drain interface (MCU_EN frame strobe, MCU_CLOCK, MCU_DATA).
- Runs a configurable boot sequence: firmware-version frame, then logo frame.
- After boot, arbitrates two frame sources:
  - N_EVT edge-detected event inputs (PTT, TX inhibit, etc.) that generate one-byte commands.
  - A host command port with variable payload length and a valid/ready handshake.
- Sits in the slow-clock domain next to the radio control logic.

---
 rtl/mcu_link_pkg.sv | 38 +++
 rtl/mcu_byte_shifter.sv | 81 ++++++++
 rtl/mcu_cmd_link.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_link_pkg.sv
// Shared types and command codes for the front-panel MCU serial command link.
package mcu_link_pkg;

  typedef enum logic [2:0] {
    StBootWait,
    StSendVer,
    StLogoWait,
    StSendLogo,
    StIdle,
    StLoad,
    StFrame,
    StGap
  } state_e;

  typedef enum logic [1:0] {
    PhA,
    PhB,
    PhC
  } phase_e;

  localparam logic [7:0] CMD_FW_VERSION = 8'd1;
  localparam logic [7:0] CMD_LOGO       = 8'd2;
  localparam logic [7:0] CMD_IP         = 8'd3;
  localparam logic [7:0] CMD_BOOTLOADER = 8'd4;
  localparam logic [7:0] CMD_PTT_ON     = 8'd5;
  localparam logic [7:0] CMD_PTT_OFF    = 8'd6;

  // Code byte plus up to 15 payload bytes.
  localparam int unsigned BUF_BYTES = 16;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mcu_byte_shifter.sv
// Shifts one byte MSB first: per bit, data setup, clock low, clock high, each HALF_BIT clocks.
module mcu_byte_shifter
  import mcu_link_pkg::*;
#(
  parameter int unsigned HALF_BIT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       data_low,
  output logic       clock_low,
  output logic       done
);

  localparam int unsigned HbW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
  localparam logic [HbW-1:0] HbLast = HbW'(HALF_BIT - 1);

  logic           active_q, active_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [2:0]     bit_q, bit_d;
  phase_e         phase_q, phase_d;
  logic [HbW-1:0] cnt_q, cnt_d;
  logic           tick;

  assign tick      = (cnt_q == HbLast);
  // Asserted on the final clock of bit 0 so the next byte can start without a bubble.
  assign done      = active_q && (phase_q == PhC) && tick && (bit_q == 3'd0);
  assign data_low  = active_q && !shreg_q[bit_q];
  assign clock_low = active_q && (phase_q == PhB);

  always_comb begin
    active_d = active_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    if (start) begin
      active_d = 1'b1;
      shreg_d  = byte_in;
      bit_d    = 3'd7;
      phase_d  = PhA;
      cnt_d    = '0;
    end else if (active_q) begin
      if (!tick) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
        unique case (phase_q)
          PhA: phase_d = PhB;
          PhB: phase_d = PhC;
          default: begin
            phase_d = PhA;
            if (bit_q == 3'd0) begin
              active_d = 1'b0;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= 1'b0;
      shreg_q  <= '0;
      bit_q    <= '0;
      phase_q  <= PhA;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mcu_cmd_link.sv
// Front-panel MCU command link: boot frames, then event/host frame arbitration onto
// a 3-wire open-drain bus (MCU_EN, MCU_CLOCK, MCU_DATA).
module mcu_cmd_link
  import mcu_link_pkg::*;
#(
  parameter logic [63:0] FW_VERSION  = "no ver",
  parameter int unsigned MAX_PAYLOAD = 8,
  parameter int unsigned N_EVT       = 1,
  parameter int unsigned EVT_BASE    = 5,
  parameter int unsigned HALF_BIT    = 1,
  parameter int unsigned BOOT_DELAY  = 4000,
  parameter int unsigned LOGO_DELAY  = 240000,
  parameter int unsigned FRAME_GAP   = 4000,
  parameter bit          BOOT_EN     = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  inout  wire                      MCU_RES,
  inout  wire                      MCU_DATA,
  inout  wire                      MCU_CLOCK,
  inout  wire                      MCU_EN,
  input  logic [N_EVT-1:0]         evt_in,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_code,
  input  logic [3:0]               cmd_len,
  input  logic [8*MAX_PAYLOAD-1:0] cmd_payload,
  output logic                     busy,
  output logic                     boot_done,
  output logic                     cmd_err
);

  localparam int unsigned MaxDelay = max3(BOOT_DELAY, LOGO_DELAY, FRAME_GAP);
  localparam int unsigned CntW     = $clog2(MaxDelay + 1);

  state_e                          state_q, state_d;
  state_e                          ret_q, ret_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic                            boot_done_q, boot_done_d;
  logic                            cmd_err_q, cmd_err_d;
  logic [BUF_BYTES-1:0][7:0]       buf_q, buf_d;
  logic [3:0]                      len_q, len_d;
  logic [3:0]                      idx_q, idx_d;
  logic [3:0]                      idx_nxt;

  logic [N_EVT-1:0] shadow_q, lvl_q, pend_q, sent_q;
  logic [N_EVT-1:0] edge_v, lvl_cur, pend_cur, pend_d, sent_d, svc;
  logic             evt_any;
  logic [7:0]       evt_code;

  logic       shift_start, shift_done, data_low, clock_low, en_low;
  logic [7:0] shift_byte;

  function automatic logic reached(input logic [CntW-1:0] c, input int unsigned lim);
    return (32'(c) + 32'd1) >= lim;
  endfunction

  mcu_byte_shifter #(
    .HALF_BIT (HALF_BIT)
  ) u_shifter (
    .clock     (clock),
    .reset     (reset),
    .start     (shift_start),
    .byte_in   (shift_byte),
    .data_low  (data_low),
    .clock_low (clock_low),
    .done      (shift_done)
  );

  // Events: apply this cycle's edges first so arbitration and cmd_ready see them at once.
  always_comb begin
    edge_v   = evt_in ^ shadow_q;
    lvl_cur  = lvl_q;
    pend_cur = pend_q;
    for (int i = 0; i < N_EVT; i++) begin
      if (edge_v[i]) begin
        lvl_cur[i]  = evt_in[i];
        pend_cur[i] = evt_in[i] ^ sent_q[i];
      end
    end
    svc      = '0;
    evt_any  = 1'b0;
    evt_code = '0;
    for (int i = 0; i < N_EVT; i++) begin
      if (pend_cur[i] && !evt_any) begin
        evt_any  = 1'b1;
        svc[i]   = 1'b1;
        evt_code = 8'(EVT_BASE + 2 * i + (lvl_cur[i] ? 0 : 1));
      end
    end
  end

  assign idx_nxt = idx_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    boot_done_d = boot_done_q;
    cmd_err_d   = 1'b0;
    buf_d       = buf_q;
    len_d       = len_q;
    idx_d       = idx_q;
    pend_d      = pend_cur;
    sent_d      = sent_q;
    shift_start = 1'b0;
    shift_byte  = buf_q[0];
    en_low      = 1'b0;
    cmd_ready   = 1'b0;

    unique case (state_q)
      StBootWait: begin
        if (reached(cnt_q, BOOT_DELAY)) begin
          cnt_d = '0;
          if (BOOT_EN) begin
            state_d  = StSendVer;
            buf_d[0] = CMD_FW_VERSION;
            for (int k = 0; k < 8; k++) begin
              buf_d[k+1] = FW_VERSION[63-8*k -: 8];
            end
            len_d       = 4'd8;
            idx_d       = '0;
            shift_start = 1'b1;
            shift_byte  = CMD_FW_VERSION;
          end else begin
            state_d     = StIdle;
            boot_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StLogoWait: begin
        if (reached(cnt_q, LOGO_DELAY)) begin
          cnt_d       = '0;
          state_d     = StSendLogo;
          buf_d[0]    = CMD_LOGO;
          len_d       = '0;
          idx_d       = '0;
          shift_start = 1'b1;
          shift_byte  = CMD_LOGO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StSendVer, StSendLogo, StFrame: begin
        en_low = 1'b1;
        if (shift_done) begin
          if (idx_q == len_q) begin
            state_d = StGap;
            cnt_d   = '0;
            ret_d   = (state_q == StSendVer) ? StLogoWait : StIdle;
          end else begin
            idx_d       = idx_nxt;
            shift_start = 1'b1;
            shift_byte  = buf_q[idx_nxt];
          end
        end
      end

      StGap: begin
        if (reached(cnt_q, FRAME_GAP)) begin
          cnt_d   = '0;
          state_d = ret_q;
          if (ret_q == StIdle) begin
            boot_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StIdle: begin
        if (evt_any) begin
          pend_d   = pend_cur & ~svc;
          sent_d   = (sent_q & ~svc) | (lvl_cur & svc);
          buf_d[0] = evt_code;
          len_d    = '0;
          state_d  = StLoad;
        end else if (boot_done_q) begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            if (32'(cmd_len) > MAX_PAYLOAD) begin
              cmd_err_d = 1'b1;
            end else begin
              buf_d[0] = cmd_code;
              for (int k = 0; k < MAX_PAYLOAD; k++) begin
                buf_d[k+1] = cmd_payload[8*k +: 8];
              end
              len_d   = cmd_len;
              state_d = StLoad;
            end
          end
        end
      end

      StLoad: begin
        idx_d       = '0;
        shift_start = 1'b1;
        shift_byte  = buf_q[0];
        state_d     = StFrame;
      end

      default: state_d = StBootWait;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StBootWait;
      ret_q       <= StIdle;
      cnt_q       <= '0;
      boot_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      buf_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      // Current levels count as already reported, so reset release raises no event.
      shadow_q    <= evt_in;
      lvl_q       <= evt_in;
      sent_q      <= evt_in;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      boot_done_q <= boot_done_d;
      cmd_err_q   <= cmd_err_d;
      buf_q       <= buf_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      shadow_q    <= evt_in;
      lvl_q       <= lvl_cur;
      sent_q      <= sent_d;
      pend_q      <= pend_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign boot_done = boot_done_q;
  assign cmd_err   = cmd_err_q;

  assign MCU_RES   = 1'bz;
  assign MCU_EN    = en_low ? 1'b0 : 1'bz;
  assign MCU_DATA  = data_low ? 1'b0 : 1'bz;
  assign MCU_CLOCK = clock_low ? 1'b0 : 1'bz;

endmodule
